// File: rtl/hex_display_mux.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, frame-synchronous
// display update, leading-zero blanking, registered segment/anode outputs.

module hex_seg_dec (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  // Active-high pattern, bit0..6 = a..g, bit7 = dp
  logic [6:0] s;
  always_comb begin
    s = 7'h00;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
  end
  assign seg = {dp, s};
endmodule

module hex_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int SEG_ON     = 0,
  parameter int DIG_ON     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // XOR masks turn active-high internal patterns into the configured levels
  localparam logic [7:0]            SEG_XOR = {8{SEG_ON == 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_XOR = {NUM_DIGITS{DIG_ON == 0}};

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   pend_val, disp_val;
  logic [NUM_DIGITS-1:0]        pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0][7:0]   dig_seg;
  logic [NUM_DIGITS:0]          lz_chain;
  logic                         tick, wrap, blank;
  logic [7:0]                   cur_seg;
  logic [NUM_DIGITS-1:0]        onehot;

  assign tick = enable && (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // lz_chain[k]: digits k..top are all zero with no dp
  assign lz_chain[NUM_DIGITS] = 1'b1;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    hex_seg_dec u_dec (.nib(disp_val[k]), .dp(disp_dp[k]), .seg(dig_seg[k]));
    assign lz_chain[k] = lz_chain[k+1] && (disp_val[k] == 4'h0) && !disp_dp[k];
  end

  assign blank   = blank_lz && (idx != '0) && lz_chain[idx];
  assign cur_seg = dig_seg[idx];
  assign onehot  = NUM_DIGITS'(1) << idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      frame_done <= 1'b0;
      seg_out    <= SEG_XOR;
      an_out     <= DIG_XOR;
    end else begin
      if (tick)        cnt <= '0;
      else if (enable) cnt <= cnt + 1'b1;

      if (tick) idx <= wrap ? '0 : idx + 1'b1;

      if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
      end

      // Display only changes at frame boundary; a coinciding load bypasses pending
      if (wrap) begin
        disp_val <= load ? value_in : pend_val;
        disp_dp  <= load ? dp_in    : pend_dp;
      end

      frame_done <= wrap;
      seg_out    <= ((enable && !blank) ? cur_seg : 8'h00) ^ SEG_XOR;
      an_out     <= (enable ? onehot : '0) ^ DIG_XOR;
    end
  end
endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux (4 digits, 4-cycle slots, active-low outputs).

module tb_hex_display_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load, enable, blank_lz;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  localparam logic [3:0][7:0] ZERO = {4{8'hC0}};
  localparam logic [3:0][7:0] V1A8F = {8'hF9, 8'h88, 8'h80, 8'h8E};
  localparam logic [3:0][7:0] V5    = {8'hFF, 8'hFF, 8'hFF, 8'h92};
  localparam logic [3:0][7:0] V5DP  = {8'hFF, 8'h40, 8'hC0, 8'h92};
  localparam logic [3:0][7:0] V7    = {8'hFF, 8'hFF, 8'hFF, 8'hF8};
  localparam logic [3:0][7:0] V3    = {8'hFF, 8'hFF, 8'hFF, 8'hB0};

  hex_display_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ON(0), .DIG_ON(0)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
    .enable(enable), .blank_lz(blank_lz), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of normal scanning; pos is the slot position this edge presents
  task automatic tick_chk(input logic [3:0][7:0] e);
    int d;
    @(posedge clk); #1;
    d = pos / 4;
    chk($sformatf("an p%0d", pos), 32'(an_out), 32'(~(4'b0001 << d) & 4'hF));
    chk($sformatf("seg p%0d", pos), 32'(seg_out), 32'(e[d]));
    chk($sformatf("fd p%0d", pos), 32'(frame_done), 32'(pos == 15));
    pos = (pos + 1) % 16;
  endtask

  task automatic run(input int n, input logic [3:0][7:0] e);
    repeat (n) tick_chk(e);
  endtask

  task automatic dark_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, " an"}, 32'(an_out), 32'hF);
    chk({tag, " seg"}, 32'(seg_out), 32'hFF);
    chk({tag, " fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; blank_lz = 1'b0; load = 1'b0;
    value_in = 16'h0; dp_in = 4'h0;
    repeat (3) @(posedge clk); #1;
    chk("rst an", 32'(an_out), 32'hF);
    chk("rst seg", 32'(seg_out), 32'hFF);
    chk("rst fd", 32'(frame_done), 32'h0);
    rst = 1'b0; pos = 0;

    // Plain scan of zeros
    run(16, ZERO);

    // Mid-frame load held until wrap
    run(1, ZERO);
    value_in = 16'h1A8F; load = 1'b1;
    run(1, ZERO);
    load = 1'b0;
    run(14, ZERO);
    run(16, V1A8F);

    // Leading-zero blanking, then dp stops blanking
    value_in = 16'h0005; dp_in = 4'b0000; blank_lz = 1'b1; load = 1'b1;
    run(1, V1A8F);
    load = 1'b0;
    run(15, V1A8F);
    run(16, V5);
    dp_in = 4'b0100; load = 1'b1;
    run(1, V5);
    load = 1'b0;
    run(15, V5);
    run(16, V5DP);

    // Load coinciding with wrap goes straight to display
    run(15, V5DP);
    value_in = 16'h0007; dp_in = 4'b0000; load = 1'b1;
    run(1, V5DP);
    load = 1'b0;
    run(16, V7);

    // Freeze mid-slot; load while frozen is kept for the next wrap
    run(6, V7);
    enable = 1'b0; value_in = 16'h0003; load = 1'b1;
    dark_chk("off0");
    load = 1'b0;
    for (int i = 1; i < 10; i++) dark_chk($sformatf("off%0d", i));
    enable = 1'b1;
    run(10, V7);
    run(16, V3);

    // Reset between load and wrap discards pending data
    run(5, V3);
    value_in = 16'hBEEF; load = 1'b1;
    run(1, V3);
    load = 1'b0;
    run(2, V3);
    #2 rst = 1'b1;
    #1;
    chk("mid rst an", 32'(an_out), 32'hF);
    chk("mid rst seg", 32'(seg_out), 32'hFF);
    chk("mid rst fd", 32'(frame_done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; pos = 0; blank_lz = 1'b0;
    run(32, ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
